// File: rtl/tq1m_pkg.sv
// Shared types and constants for the tq1m DAC sample path.
// DOUT_WIDTH sets the default DAC code width when not supplied by the build.
`ifndef DOUT_WIDTH
`define DOUT_WIDTH 10
`endif

package tq1m_pkg;

    localparam int unsigned DATA_W_DEF = `DOUT_WIDTH;

    // Shift-right Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        RAMP        = 2'd0,
        TRI         = 2'd1,
        SQUARE      = 2'd2,
        CONST_NOISE = 2'd3
    } Mode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        SQ_LO = 3'd3,
        SQ_HI = 3'd4,
        CONST = 3'd5
    } PatState_t;

endpackage

// File: rtl/dac_pattern_gen_lfsr.sv
// 16-bit Fibonacci LFSR for the noise waveform; only built with PATGEN_NOISE_EN.
// Advance takes priority over reseed so the first request out of IDLE steps off the seed.
`ifdef PATGEN_NOISE_EN
module patgen_lfsr
    import tq1m_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        reseed,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LFSR_SEED;
        end else if (enable) begin
            state <= {^(state & LFSR_TAPS), state[15:1]};
        end else if (reseed) begin
            state <= LFSR_SEED;
        end
    end

endmodule
`endif

// File: rtl/dac_pattern_gen.sv
// Waveform sample source for the tq1m DAC: ramp, triangle, square, constant.
// Define PATGEN_NOISE_EN to turn mode 3 into bounded LFSR noise.
module dac_pattern_gen
    import tq1m_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned HALF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] step,
    input  logic [DATA_W-1:0] lo,
    input  logic [DATA_W-1:0] hi,
    input  logic [HALF_W-1:0] half_len,
    input  logic              sample_req,
    output logic [DATA_W-1:0] sample,
    output logic              sample_vld,
    output logic              period_strb,
    output logic              cfg_err
);

    PatState_t         state, state_n;
    Mode_t             mode_in, sh_mode;
    logic [DATA_W-1:0] sh_step, sh_lo, sh_hi, sample_n;
    logic [HALF_W-1:0] sh_half, cnt, cnt_n, half_eff;
    logic [DATA_W:0]   up_sum, down_floor;
    logic              vld_n, strb_n, latch, wrap;

    assign mode_in    = Mode_t'(mode);
    assign up_sum     = {1'b0, sample} + {1'b0, sh_step};
    assign down_floor = {1'b0, sh_lo} + {1'b0, sh_step};
    assign half_eff   = (sh_half == '0) ? HALF_W'(1) : sh_half;

`ifdef PATGEN_NOISE_EN
    logic [15:0]       lfsr;
    logic [DATA_W-1:0] noise_cur, noise_new;

    // Restoring remainder: v mod r with one compare/subtract per quotient bit.
    function automatic logic [DATA_W-1:0] fold_mod(input logic [DATA_W-1:0] v,
                                                   input logic [DATA_W:0]   r);
        logic [2*DATA_W:0] rem;
        logic [2*DATA_W:0] d;
        rem = (2*DATA_W+1)'(v);
        for (int unsigned k = DATA_W; k > 0; k--) begin
            d = (2*DATA_W+1)'(r) << (k - 1);
            if (rem >= d) rem = rem - d;
        end
        return rem[DATA_W-1:0];
    endfunction

    patgen_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .enable (enable && sample_req),
        .reseed (!enable || state == IDLE),
        .state  (lfsr)
    );

    assign noise_cur = sh_lo + fold_mod(lfsr[DATA_W-1:0],
                                        {1'b0, sh_hi} - {1'b0, sh_lo} + (DATA_W+1)'(1));
    assign noise_new = lo + fold_mod(lfsr[DATA_W-1:0],
                                     {1'b0, hi} - {1'b0, lo} + (DATA_W+1)'(1));
`endif

    always_comb begin
        state_n  = state;
        sample_n = sample;
        cnt_n    = cnt;
        vld_n    = 1'b0;
        strb_n   = 1'b0;
        latch    = 1'b0;
        wrap     = 1'b0;
        if (!enable) begin
            state_n = IDLE;
        end else if (sample_req) begin
            vld_n = 1'b1;
            case (state)
                IDLE: wrap = 1'b1;
                UP: begin
                    if (sh_mode == RAMP) begin
                        if (up_sum > {1'b0, sh_hi}) wrap = 1'b1;
                        else sample_n = up_sum[DATA_W-1:0];
                    end else if (sh_step != '0) begin
                        if (up_sum >= {1'b0, sh_hi}) begin
                            sample_n = sh_hi;
                            state_n  = DOWN;
                        end else begin
                            sample_n = up_sum[DATA_W-1:0];
                        end
                    end
                end
                DOWN: begin
                    if (sh_step != '0) begin
                        if ({1'b0, sample} <= down_floor) wrap = 1'b1;
                        else sample_n = sample - sh_step;
                    end
                end
                SQ_LO: begin
                    if (cnt >= half_eff) begin
                        sample_n = sh_hi;
                        cnt_n    = HALF_W'(1);
                        state_n  = SQ_HI;
                    end else begin
                        sample_n = sh_lo;
                        cnt_n    = cnt + HALF_W'(1);
                    end
                end
                SQ_HI: begin
                    if (cnt >= half_eff) begin
                        wrap = 1'b1;
                    end else begin
                        sample_n = sh_hi;
                        cnt_n    = cnt + HALF_W'(1);
                    end
                end
                CONST: begin
`ifdef PATGEN_NOISE_EN
                    if (sh_mode == CONST_NOISE && lfsr != LFSR_SEED) sample_n = noise_cur;
                    else wrap = 1'b1;
`else
                    wrap = 1'b1;
`endif
                end
                default: state_n = IDLE;
            endcase

            // A bad latched range forces a fresh period (and relatch) on every request.
            if (cfg_err) wrap = 1'b1;

            if (wrap) begin
                latch    = 1'b1;
                strb_n   = 1'b1;
                cnt_n    = HALF_W'(1);
                sample_n = lo;
                case (mode_in)
                    RAMP, TRI: state_n = UP;
                    SQUARE:    state_n = SQ_LO;
                    default:   state_n = CONST;
                endcase
`ifdef PATGEN_NOISE_EN
                if (mode_in == CONST_NOISE && lo <= hi) sample_n = noise_new;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sample      <= '0;
            sample_vld  <= 1'b0;
            period_strb <= 1'b0;
            cfg_err     <= 1'b0;
            cnt         <= '0;
            sh_mode     <= RAMP;
            sh_step     <= '0;
            sh_lo       <= '0;
            sh_hi       <= '0;
            sh_half     <= '0;
        end else begin
            state       <= state_n;
            sample      <= sample_n;
            sample_vld  <= vld_n;
            period_strb <= strb_n;
            cnt         <= cnt_n;
            if (latch) begin
                sh_mode <= mode_in;
                sh_step <= step;
                sh_lo   <= lo;
                sh_hi   <= hi;
                sh_half <= half_len;
                cfg_err <= (lo > hi);
            end
        end
    end

endmodule
